// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
//   Pipelined barrel shifter for the execute stage. It is a log2(N)-level
//   shifter supporting SLL, SRL, SRA and ROL. The levels are grouped into
//   register slices of LEVELS_PER_STAGE levels each. Operations move under a
//   valid/ready handshake with backpressure and flush. An opaque tag travels
//   with each result.
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   flush     : synchronous squash of every in-flight operation
//   in_valid  : operation offered          in_ready : block can accept
//   in_data   : operand (N bits)           in_sa    : shift amount
//   in_op     : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag    : opaque tag (TW bits)
//   out_valid : result valid               out_ready: consumer accepts
//   out_data  : result (N bits)            out_tag  : tag of the result
// ---------------------------------------------------------------------------
module shift_pipe #(
  parameter int N                = 32,
  parameter int LOG2N            = $clog2(N),
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TW               = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [LOG2N-1:0] in_sa,
  input  logic [1:0]       in_op,
  input  logic [TW-1:0]    in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TW-1:0]    out_tag
);

  localparam int L = (LOG2N + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One shift level by s positions with the fill rule of the selected mode.
  function automatic logic [N-1:0] level_shift(input logic [N-1:0] a,
                                               input int         s,
                                               input logic [1:0] op,
                                               input logic       sign);
    logic [N-1:0] r;
    case (op)
      OP_SLL:  r = a << s;
      OP_SRL:  r = a >> s;
      // Vacated MSBs take the original operand's sign, not a[N-1] of the
      // partially shifted value.
      OP_SRA:  r = (a >> s) | ({N{sign}} & ~({N{1'b1}} >> s));
      default: r = (a << s) | (a >> (N - s));
    endcase
    return r;
  endfunction

  // Levels lo..hi-1 of the shifter, applied in ascending order.
  function automatic logic [N-1:0] slice_shift(input logic [N-1:0]     a,
                                               input logic [LOG2N-1:0] sa,
                                               input logic [1:0]       op,
                                               input logic             sign,
                                               input int               lo,
                                               input int               hi);
    logic [N-1:0]     r;
    logic [LOG2N-1:0] sa_k;
    r = a;
    for (int k = 0; k < LOG2N; k++) begin
      sa_k = sa >> k;
      if (k >= lo && k < hi && sa_k[0]) begin
        r = level_shift(r, 1 << k, op, sign);
      end
    end
    return r;
  endfunction

  // Slice registers. The full shift amount is carried; each slice only
  // looks at its own bits, so the consumed bits are simply ignored.
  logic             valid_q [L];
  logic [N-1:0]     data_q  [L];
  logic [LOG2N-1:0] sa_q    [L];
  logic [1:0]       op_q    [L];
  logic             sign_q  [L];
  logic [TW-1:0]    tag_q   [L];

  // Inputs of each slice (predecessor register, or the ports for slice 0).
  logic             src_valid [L];
  logic [N-1:0]     src_data  [L];
  logic [LOG2N-1:0] src_sa    [L];
  logic [1:0]       src_op    [L];
  logic             src_sign  [L];
  logic [TW-1:0]    src_tag   [L];
  logic [N-1:0]     data_d    [L];

  logic en;

  // Global stall: the whole pipe advances only when the output slot is free
  // or being consumed, so bubbles are never squeezed out under a stall.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;

  for (genvar gi = 0; gi < L; gi++) begin : g_slice
    localparam int LO = gi * LEVELS_PER_STAGE;
    localparam int HI = (LO + LEVELS_PER_STAGE > LOG2N) ? LOG2N : LO + LEVELS_PER_STAGE;

    if (gi == 0) begin : g_head
      assign src_valid[gi] = in_valid;
      assign src_data[gi]  = in_data;
      assign src_sa[gi]    = in_sa;
      assign src_op[gi]    = in_op;
      assign src_sign[gi]  = in_data[N-1];
      assign src_tag[gi]   = in_tag;
    end else begin : g_body
      assign src_valid[gi] = valid_q[gi-1];
      assign src_data[gi]  = data_q[gi-1];
      assign src_sa[gi]    = sa_q[gi-1];
      assign src_op[gi]    = op_q[gi-1];
      assign src_sign[gi]  = sign_q[gi-1];
      assign src_tag[gi]   = tag_q[gi-1];
    end

    assign data_d[gi] = slice_shift(src_data[gi], src_sa[gi], src_op[gi],
                                    src_sign[gi], LO, HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < L; j++) begin
        valid_q[j] <= 1'b0;
        data_q[j]  <= '0;
        sa_q[j]    <= '0;
        op_q[j]    <= '0;
        sign_q[j]  <= 1'b0;
        tag_q[j]   <= '0;
      end
    end else begin
      if (en) begin
        for (int j = 0; j < L; j++) begin
          valid_q[j] <= src_valid[j];
          data_q[j]  <= data_d[j];
          sa_q[j]    <= src_sa[j];
          op_q[j]    <= src_op[j];
          sign_q[j]  <= src_sign[j];
          tag_q[j]   <= src_tag[j];
        end
      end
      // Flush overrides the load, so an op offered in a flush cycle dies too.
      if (flush) begin
        for (int j = 0; j < L; j++) begin
          valid_q[j] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
  localparam int N   = 32;
  localparam int L   = 3;
  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [4:0]    in_sa;
  logic [1:0]    in_op;
  logic [4:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [4:0]    out_tag;

  shift_pipe #(.N(32), .LEVELS_PER_STAGE(2), .TW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sa    (in_sa),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          exp_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got tag %0d data 0x%08h, expected no result",
                 out_tag, out_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_data", out_data, mon_e.data);
        check("result_tag", {27'b0, out_tag}, {27'b0, mon_e.tag});
        if (mon_e.chk_lat) check("result_latency", 32'(cyc), 32'(mon_e.exp_cyc));
        $display("result tag=%0d data=0x%08h cycle=%0d expected tag=%0d data=0x%08h",
                 out_tag, out_data, cyc, mon_e.tag, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for one cycle; the bench's own model decides acceptance and
  // records the expected result when keep is set.
  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa,
                       input logic [4:0] tag, input logic [31:0] exp, input bit chk_lat,
                       input bit keep);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_sa    = sa;
    in_tag   = tag;
    #1;
    if (keep && in_ready && !flush && !reset) begin
      e.data    = exp;
      e.tag     = tag;
      e.exp_cyc = cyc + L;
      e.chk_lat = chk_lat;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d results outstanding after timeout, expected 0", name, sb_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sa     = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_tag", {27'b0, out_tag}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Modes, one at a time, latency checked
    issue(SLL, 32'h00000001, 5'd31, 5'd1, 32'h80000000, 1, 1); drain("sll31");
    issue(SRL, 32'hF0000000, 5'd28, 5'd2, 32'h0000000F, 1, 1); drain("srl28");
    issue(SRA, 32'h80000000, 5'd4,  5'd3, 32'hF8000000, 1, 1); drain("sra4");
    issue(ROL, 32'h80000001, 5'd1,  5'd4, 32'h00000003, 1, 1); drain("rol1");
    // Identity and boundaries
    issue(SLL, 32'hA5A5A5A5, 5'd0,  5'd5, 32'hA5A5A5A5, 1, 1); drain("sll0");
    issue(SRL, 32'hA5A5A5A5, 5'd0,  5'd6, 32'hA5A5A5A5, 1, 1); drain("srl0");
    issue(SRA, 32'hA5A5A5A5, 5'd0,  5'd7, 32'hA5A5A5A5, 1, 1); drain("sra0");
    issue(ROL, 32'hA5A5A5A5, 5'd0,  5'd8, 32'hA5A5A5A5, 1, 1); drain("rol0");
    issue(SRA, 32'h7FFFFFFF, 5'd31, 5'd9, 32'h00000000, 1, 1); drain("sra31_pos");
    issue(ROL, 32'h12345678, 5'd16, 5'd10, 32'h56781234, 1, 1); drain("rol16");

    // Back-to-back: results on consecutive cycles via per-op latency check
    issue(SLL, 32'h0000000F, 5'd4,  5'd0, 32'h000000F0, 1, 1);
    issue(SRL, 32'h0000F000, 5'd12, 5'd1, 32'h0000000F, 1, 1);
    issue(SRA, 32'hF0000000, 5'd8,  5'd2, 32'hFFF00000, 1, 1);
    issue(ROL, 32'hF000000F, 5'd4,  5'd3, 32'h000000FF, 1, 1);
    issue(SLL, 32'hFFFFFFFF, 5'd16, 5'd4, 32'hFFFF0000, 1, 1);
    issue(SRL, 32'h80000000, 5'd31, 5'd5, 32'h00000001, 1, 1);
    issue(SRA, 32'h80000000, 5'd31, 5'd6, 32'hFFFFFFFF, 1, 1);
    issue(ROL, 32'h00000001, 5'd31, 5'd7, 32'h80000000, 1, 1);
    drain("back_to_back");

    // Backpressure
    out_ready = 1'b0;
    issue(SLL, 32'h00000003, 5'd2, 5'd10, 32'h0000000C, 0, 1);
    issue(SRL, 32'h00000100, 5'd8, 5'd11, 32'h00000001, 0, 1);
    issue(ROL, 32'h80000000, 5'd3, 5'd12, 32'h00000004, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_data", out_data, 32'h0000000C);
      check("stall_out_tag", {27'b0, out_tag}, 32'd10);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain("backpressure");

    // Flush one cycle after two accepts; the op offered alongside is dropped
    issue(SLL, 32'h00000001, 5'd1, 5'd13, 32'h0, 0, 0);
    issue(SLL, 32'h00000001, 5'd2, 5'd14, 32'h0, 0, 0);
    flush = 1'b1;
    issue(SLL, 32'h00000001, 5'd3, 5'd15, 32'h00000008, 1, 1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    issue(SRA, 32'hC0000000, 5'd1, 5'd20, 32'hE0000000, 1, 1);
    drain("after_flush");

    // Reset with the pipe full
    out_ready = 1'b0;
    issue(SLL, 32'h0000FFFF, 5'd3, 5'd21, 32'h0, 0, 0);
    issue(SRL, 32'hFFFF0000, 5'd3, 5'd22, 32'h0, 0, 0);
    issue(ROL, 32'h12345678, 5'd3, 5'd23, 32'h0, 0, 0);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_reset_out_data", out_data, 32'd0);
    check("mid_reset_out_tag", {27'b0, out_tag}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    issue(SLL, 32'h00000005, 5'd1, 5'd30, 32'h0000000A, 1, 1);
    drain("after_reset");
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
